alu_share_arbiter: RTL and testbench

Shares one combinational ALU instance between NUM_REQ requesters, such as the integer issue path and a multi-cycle address/compare sequencer. Each requester has a valid/ready request channel and a valid/ready response channel. Grants are round-robin, at most one operation per cycle. Each result is registered into the winning requester's private response buffer, so latency is one cycle and each requester's backpressure is independent of the others.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu.sv | 31 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/alu_share_arbiter.sv | 97 +++++++++
 tb/tb_alu_share_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and widths, imported by the ALU and the arbiter top
// so the codes cannot drift between them.
package alu_pkg;
    localparam int OP_W   = 4;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b0010;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b0011;
    localparam logic [OP_W-1:0] OP_SLTU = 4'b0100;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b0110;
    localparam logic [OP_W-1:0] OP_SRA  = 4'b0111;
    localparam logic [OP_W-1:0] OP_OR   = 4'b1000;
    localparam logic [OP_W-1:0] OP_AND  = 4'b1001;
    localparam logic [OP_W-1:0] OP_LUI  = 4'b1010;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return op <= OP_LUI;
    endfunction
endpackage

// File: rtl/alu.sv
// Combinational integer ALU; zero latency, no flow control.
// LUI passes operand B through (the immediate arrives pre-shifted).
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result
);
    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_SLL:  o_result = i_a << w_shamt;
            OP_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            OP_SLTU: o_result = {31'd0, i_a < i_b};
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SRL:  o_result = i_a >> w_shamt;
            OP_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            OP_OR:   o_result = i_a | i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_LUI:  o_result = i_b;
            default: o_result = '0;
        endcase
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant, pointer updates one cycle later on i_update.
// Searches upward from pointer+1; grants nothing while i_reset is high.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_req,
    input  logic         i_update,
    output logic [N-1:0] o_grant,
    output logic [1:0]   o_grant_idx
);
    logic [1:0] r_ptr;
    logic       w_found;
    int         w_dist;
    int         w_best;

    // Distance from pointer+1 (mod N); the eligible index with the smallest one wins.
    always_comb begin
        w_found     = 1'b0;
        w_best      = N;
        w_dist      = 0;
        o_grant_idx = 2'd0;
        for (int k = 0; k < N; k++) begin
            w_dist = (k + 2 * N - int'(r_ptr) - 1) % N;
            if (i_req[k] && !i_reset && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_found     = 1'b1;
                o_grant_idx = 2'(k);
            end
        end
        o_grant = '0;
        for (int k = 0; k < N; k++) begin
            o_grant[k] = w_found && (o_grant_idx == 2'(k));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= 2'(N - 1);
        end else if (i_update) begin
            r_ptr <= o_grant_idx;
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared round-robin by NUM_REQ requesters; result registered per requester, 1-cycle latency.
// A requester is only granted when its own response slot is free or draining, so backpressure is independent.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int OP_W    = alu_pkg::OP_W
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_op_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_op_b,
    input  logic [NUM_REQ*OP_W-1:0]   i_req_alu_op,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    input  logic [NUM_REQ-1:0]        i_rsp_ready,
    output logic [NUM_REQ*DATA_W-1:0] o_rsp_data,
    output logic [NUM_REQ-1:0]        o_rsp_err,
    output logic [1:0]                o_grant_id,
    output logic                      o_busy
);
    logic [NUM_REQ-1:0]        r_rsp_valid;
    logic [NUM_REQ*DATA_W-1:0] r_rsp_data;
    logic [NUM_REQ-1:0]        r_rsp_err;
    logic [NUM_REQ-1:0]        w_eligible;
    logic [NUM_REQ-1:0]        w_grant;
    logic [1:0]                w_grant_idx;
    logic                      w_busy;
    logic [DATA_W-1:0]         w_alu_a;
    logic [DATA_W-1:0]         w_alu_b;
    logic [OP_W-1:0]           w_alu_op;
    logic [DATA_W-1:0]         w_alu_res;
    logic                      w_legal;

    // A full slot being drained this cycle counts as free.
    assign w_eligible = i_req_valid & (~r_rsp_valid | i_rsp_ready);
    assign w_busy     = |w_grant;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req       (w_eligible),
        .i_update    (w_busy),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Idle ALU inputs are held at ADD 0,0 to avoid toggling.
    always_comb begin
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alu_op = OP_ADD;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_alu_a  = i_req_op_a[k*DATA_W +: DATA_W];
                w_alu_b  = i_req_op_b[k*DATA_W +: DATA_W];
                w_alu_op = i_req_alu_op[k*OP_W +: OP_W];
            end
        end
    end

    alu u_alu (
        .i_op     (w_alu_op),
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .o_result (w_alu_res)
    );

    assign w_legal = is_legal_op(w_alu_op);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_grant[k]) begin
                    r_rsp_valid[k]                <= 1'b1;
                    r_rsp_data[k*DATA_W +: DATA_W] <= w_legal ? w_alu_res : '0;
                    r_rsp_err[k]                  <= ~w_legal;
                end else if (i_rsp_ready[k]) begin
                    r_rsp_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign o_req_ready = w_grant;
    assign o_busy      = w_busy;
    assign o_grant_id  = w_grant_idx;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two requesters and hand-computed results.
module tb_alu_share_arbiter;
    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [7:0]  alu_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_err;
    logic [1:0]  grant_id;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    alu_share_arbiter #(.NUM_REQ(2)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op_a   (op_a),
        .i_req_op_b   (op_b),
        .i_req_alu_op (alu_op),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_err    (rsp_err),
        .o_grant_id   (grant_id),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_op[k*4 +: 4] = op;
        op_a[k*32 +: 32] = a;
        op_b[k*32 +: 32] = b;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        op_a      = '0;
        op_b      = '0;
        alu_op    = '0;
        #12;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data0", rsp_data[31:0], 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        #2 rst = 1'b0;
        tick;

        // ADD 5,7 from requester 0
        set_req(0, 4'b0000, 32'd5, 32'd7);
        req_valid = 2'b01;
        #1;
        check("add_ready", 32'(req_ready), 32'd1);
        check("add_busy", 32'(busy), 32'd1);
        check("add_gid", 32'(grant_id), 32'd0);
        tick;
        req_valid = 2'b00;
        #1;
        check("add_vld", 32'(rsp_valid), 32'd1);
        check("add_data", rsp_data[31:0], 32'd12);
        check("add_err", 32'(rsp_err[0]), 32'd0);

        // Both requesters every cycle; pointer is 0, so requester 1 goes first.
        set_req(0, 4'b0001, 32'd10, 32'd3);
        set_req(1, 4'b0011, 32'hFFFF_FFFF, 32'd1);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            automatic int g = (i % 2 == 0) ? 1 : 0;
            #1;
            check("rr_gid", 32'(grant_id), 32'(g));
            check("rr_busy", 32'(busy), 32'd1);
            tick;
            check("rr_vld", 32'(rsp_valid), 32'(1 << g));
            if (g == 1) check("rr_slt", rsp_data[63:32], 32'd1);
            else        check("rr_sub", rsp_data[31:0], 32'd7);
        end
        req_valid = 2'b00;
        tick;
        check("rr_drain", 32'(rsp_valid), 32'd0);

        // Backpressure on requester 1
        set_req(1, 4'b0100, 32'hFFFF_FFFF, 32'd1);
        req_valid = 2'b10;
        rsp_ready = 2'b01;
        #1;
        check("bp_ready0", 32'(req_ready), 32'd2);
        tick;
        set_req(1, 4'b0000, 32'd3, 32'd4);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_blocked", 32'(req_ready), 32'd0);
            check("bp_idle", 32'(busy), 32'd0);
            check("bp_vld", 32'(rsp_valid[1]), 32'd1);
            check("bp_hold", rsp_data[63:32], 32'd0);
            tick;
        end
        rsp_ready = 2'b11;
        #1;
        check("bp_release", 32'(req_ready), 32'd2);
        tick;
        check("bp_reload_vld", 32'(rsp_valid[1]), 32'd1);
        check("bp_reload", rsp_data[63:32], 32'd7);
        req_valid = 2'b00;
        tick;
        check("bp_drain", 32'(rsp_valid), 32'd0);

        // Illegal opcode, then SRA
        set_req(0, 4'b1111, 32'h1234, 32'd5);
        req_valid = 2'b01;
        tick;
        check("ill_vld", 32'(rsp_valid[0]), 32'd1);
        check("ill_err", 32'(rsp_err[0]), 32'd1);
        check("ill_data", rsp_data[31:0], 32'd0);
        set_req(0, 4'b0111, 32'h8000_0000, 32'd4);
        tick;
        check("sra_data", rsp_data[31:0], 32'hF800_0000);
        check("sra_err", 32'(rsp_err[0]), 32'd0);
        req_valid = 2'b00;
        tick;

        // Asynchronous reset while a response is pending
        set_req(1, 4'b0000, 32'd1, 32'd1);
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        tick;
        req_valid = 2'b00;
        check("pre_rst_vld", 32'(rsp_valid[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_vld", 32'(rsp_valid), 32'd0);
        check("mid_rst_data1", rsp_data[63:32], 32'd0);
        #1 rst = 1'b0;
        rsp_ready = 2'b11;
        set_req(0, 4'b0000, 32'd1, 32'd2);
        set_req(1, 4'b0000, 32'd3, 32'd3);
        req_valid = 2'b11;
        #1;
        check("post_rst_gid", 32'(grant_id), 32'd0);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        tick;
        check("post_rst_data0", rsp_data[31:0], 32'd3);
        req_valid = 2'b00;
        tick;

        // Lone requester 1 with LUI, granted every cycle
        set_req(1, 4'b1010, 32'h55, 32'hABCD_E000);
        req_valid = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("lui_ready", 32'(req_ready), 32'd2);
            tick;
            check("lui_vld", 32'(rsp_valid[1]), 32'd1);
            check("lui_data", rsp_data[63:32], 32'hABCD_E000);
        end
        req_valid = 2'b00;
        tick;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
